// File: rtl/decode_stage.sv
// MIPS decode register stage: one-deep valid/ready buffer that splits the
// instruction into fields and registers the immediate-extender select.
module decode_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm16,
  output logic [1:0]       ext_op,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count
);

  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic [1:0]       ext_op_q, ext_op_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             load;
  logic             handshake;
  logic [1:0]       ext_dec;
  logic             ill_dec;

  assign in_ready  = !valid_q || out_ready;
  assign load      = in_valid && in_ready && !flush;
  assign handshake = valid_q && out_ready && !flush;

  always_comb begin
    ext_dec = 2'b00;
    ill_dec = 1'b0;
    case (in_instr[31:26])
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h23, 6'h2B, 6'h04, 6'h05: ext_dec = 2'b01;
      6'h0C, 6'h0D, 6'h0E,
      6'h02, 6'h03:               ext_dec = 2'b00;
      6'h0F:                      ext_dec = 2'b10;
      6'h00: begin
        // only the constant shifts use the shamt field
        if (in_instr[5:0] == 6'h00 || in_instr[5:0] == 6'h02 ||
            in_instr[5:0] == 6'h03)
          ext_dec = 2'b11;
      end
      default:                    ill_dec = 1'b1;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    ext_op_d  = ext_op_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    if (handshake)
      count_d = count_q + CNT_W'(1);
    if (load) begin
      instr_d   = in_instr;
      pc_d      = in_pc;
      ext_op_d  = ext_dec;
      illegal_d = ill_dec;
    end
    if (flush)
      valid_d = 1'b0;
    else if (load)
      valid_d = 1'b1;
    else if (valid_q && out_ready)
      valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      ext_op_q  <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      ext_op_q  <= ext_op_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign opcode    = instr_q[31:26];
  assign rs        = instr_q[25:21];
  assign rt        = instr_q[20:16];
  assign rd        = instr_q[15:11];
  assign imm16     = instr_q[15:0];
  assign funct     = instr_q[5:0];
  assign ext_op    = ext_op_q;
  assign illegal   = illegal_q;
  assign dec_count = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: behavioural model checked every cycle plus
// directed literal checks for the documented scenarios.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [1:0]  ext_op;
  logic [5:0]  opcode, funct;
  logic        illegal;
  logic [3:0]  dec_count;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .ext_op(ext_op), .opcode(opcode), .funct(funct),
    .illegal(illegal), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a single held instruction record plus a handshake counter.
  bit          m_valid;
  logic [31:0] m_instr, m_pc;
  logic [1:0]  m_ext;
  bit          m_ill;
  int          m_cnt;

  function automatic logic [2:0] spec_decode(input logic [31:0] ins);
    int op, fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    if (op inside {8, 9, 10, 11, 'h23, 'h2B, 4, 5}) return 3'b001;
    if (op inside {12, 13, 14, 2, 3})               return 3'b000;
    if (op == 15)                                   return 3'b010;
    if (op == 0)  return (fn inside {0, 2, 3}) ? 3'b011 : 3'b000;
    return 3'b100;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit rdy, ld;
    logic [2:0] d;
    if (!rst_n) begin
      m_valid = 0; m_instr = 0; m_pc = 0; m_ext = 0; m_ill = 0; m_cnt = 0;
    end else begin
      rdy = !m_valid || out_ready;
      ld  = in_valid && rdy && !flush;
      if (m_valid && out_ready && !flush) m_cnt = (m_cnt + 1) % 16;
      if (ld) begin
        d = spec_decode(in_instr);
        m_instr = in_instr; m_pc = in_pc; m_ext = d[1:0]; m_ill = d[2];
      end
      if (flush)                      m_valid = 0;
      else if (ld)                    m_valid = 1;
      else if (m_valid && out_ready)  m_valid = 0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready",  32'(in_ready),  32'(!m_valid || out_ready));
    chk("out_pc",    out_pc,         m_pc);
    chk("opcode",    32'(opcode),    32'(m_instr >> 26));
    chk("rs",        32'(rs),        (m_instr >> 21) % 32);
    chk("rt",        32'(rt),        (m_instr >> 16) % 32);
    chk("rd",        32'(rd),        (m_instr >> 11) % 32);
    chk("imm16",     32'(imm16),     m_instr % 65536);
    chk("funct",     32'(funct),     m_instr % 64);
    chk("ext_op",    32'(ext_op),    32'(m_ext));
    chk("illegal",   32'(illegal),   32'(m_ill));
    chk("dec_count", 32'(dec_count), 32'(m_cnt));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_pc"},    out_pc, 0);
    chk({tag, "_imm"},   32'({opcode, rs, rt, imm16}), 0);
    chk({tag, "_ext"},   32'(ext_op), 0);
    chk({tag, "_ill"},   32'(illegal), 0);
    chk({tag, "_cnt"},   32'(dec_count), 0);
  endtask

  int ops[18] = '{0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 'h23, 'h2B, 'h3F, 1, 'h20};

  initial begin
    logic [31:0] ins;
    logic [31:0] held_pc;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) cyc();
    chk_all_zero("rst");
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    // addi, then ori / lui / sll back to back
    drive(1, 32'h2008FFFF, 32'h100, 1, 0); cyc();
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_rs", 32'(rs), 0);
    chk("addi_rt", 32'(rt), 8);
    chk("addi_imm", 32'(imm16), 32'hFFFF);
    chk("addi_ext", 32'(ext_op), 1);
    chk("addi_ill", 32'(illegal), 0);
    chk("addi_cnt0", 32'(dec_count), 0);
    drive(1, 32'h350800F0, 32'h104, 1, 0); cyc();
    chk("addi_cnt1", 32'(dec_count), 1);
    chk("ori_ext", 32'(ext_op), 0);
    drive(1, 32'h3C011234, 32'h108, 1, 0); cyc();
    chk("lui_ext", 32'(ext_op), 2);
    chk("lui_rt", 32'(rt), 1);
    chk("lui_imm", 32'(imm16), 32'h1234);
    drive(1, 32'h00084080, 32'h10C, 1, 0); cyc();
    chk("sll_ext", 32'(ext_op), 3);
    chk("sll_rd", 32'(rd), 8);
    chk("sll_funct", 32'(funct), 0);
    drive(0, 0, 0, 1, 0); cyc();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_cnt", 32'(dec_count), 4);

    // stall for three cycles with a waiting instruction
    drive(1, 32'h8C220010, 32'h200, 1, 0); cyc();
    drive(1, 32'hAC230014, 32'h204, 0, 0);
    repeat (3) begin
      cyc();
      chk("stall_rdy", 32'(in_ready), 0);
      chk("stall_pc", out_pc, 32'h200);
      chk("stall_cnt", 32'(dec_count), 4);
    end
    out_ready = 1'b1; #1;
    chk("release_rdy", 32'(in_ready), 1);
    cyc();
    chk("release_cnt", 32'(dec_count), 5);
    chk("release_pc", out_pc, 32'h204);
    chk("release_valid", 32'(out_valid), 1);

    // flush against a held instruction and a new one
    drive(1, 32'h10000003, 32'h208, 0, 1); cyc();
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_cnt", 32'(dec_count), 5);

    drive(1, 32'hFC000000, 32'h300, 1, 0); cyc();
    chk("illg_ill", 32'(illegal), 1);
    chk("illg_ext", 32'(ext_op), 0);
    chk("illg_valid", 32'(out_valid), 1);

    // asynchronous reset during a stall
    drive(1, 32'h2408FFFF, 32'h304, 0, 0); cyc(); cyc();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async");
    cyc(); rst_n = 1'b1;

    // 17 handshakes wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive(1, 32'h20000000 | i, 32'(i * 4), 1, 0); cyc();
    end
    drive(0, 0, 0, 1, 0); cyc();
    chk("wrap_cnt", 32'(dec_count), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ins = $urandom;
      ins[31:26] = 6'(ops[$urandom_range(0, 17)]);
      if ($urandom_range(0, 1) == 0) ins[5:0] = 6'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 11) == 0);
      if ($urandom_range(0, 400) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      cyc();
    end
    held_pc = out_pc;
    drive(0, 0, 0, 1, 0); cyc();
    chk("final_pc_hold", out_pc, held_pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
